// File: rtl/colour_event_filter.sv
// Debounces colour-classifier frames into confirmed colour events with a
// one-deep valid/ready output, an overrun flag and a timed one-hot LED indicator.
module colour_event_filter #(
  parameter int unsigned CONFIRM_N   = 3,
  parameter int unsigned RELEASE_N   = 2,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [1:0] color,
  input  logic       detected,
  output logic       evt_valid,
  output logic [1:0] evt_color,
  input  logic       evt_ready,
  output logic [7:0] evt_count,
  output logic       overrun,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam logic [4:0]  LP_CONFIRM = 5'(CONFIRM_N);
  localparam logic [4:0]  LP_RELEASE = 5'(RELEASE_N);
  localparam logic [31:0] LP_HOLD    = 32'(HOLD_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cand;
  logic [1:0]  w_cand_nxt;
  logic [3:0]  r_streak;
  logic [3:0]  w_streak_nxt;
  logic [3:0]  r_rel;
  logic [3:0]  w_rel_nxt;
  logic [4:0]  w_streak_inc;
  logic [4:0]  w_rel_inc;
  logic        w_hit;
  logic        w_confirm;

  logic        r_evt_valid;
  logic [1:0]  r_evt_color;
  logic [7:0]  r_evt_count;
  logic        r_overrun;
  logic [31:0] r_timer;
  logic [2:0]  r_led;
  logic        w_hs;
  logic        w_load_evt;
  logic        w_drop;
  logic [2:0]  w_led_nxt;

  assign w_hit        = detected & (color != 2'd0);
  assign w_streak_inc = {1'b0, r_streak} + 5'd1;
  assign w_rel_inc    = {1'b0, r_rel} + 5'd1;

  // State register: FSM plus its candidate colour and streak/release counters.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cand   <= 2'd0;
      r_streak <= 4'd0;
      r_rel    <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cand   <= w_cand_nxt;
      r_streak <= w_streak_nxt;
      r_rel    <= w_rel_nxt;
    end
  end

  // Next-state logic; everything holds in cycles without a sample strobe.
  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_streak_nxt = r_streak;
    w_rel_nxt    = r_rel;
    w_confirm    = 1'b0;
    if (sample_valid) begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            w_state_nxt  = S_CONFIRM;
            w_cand_nxt   = color;
            w_streak_nxt = 4'd1;
          end
        end
        S_CONFIRM: begin
          if (!w_hit) begin
            w_state_nxt  = S_IDLE;
            w_streak_nxt = 4'd0;
          end else if (color == r_cand) begin
            w_streak_nxt = w_streak_inc[3:0];
            if (w_streak_inc == LP_CONFIRM) begin
              w_confirm   = 1'b1;
              w_state_nxt = S_LOCKED;
              w_rel_nxt   = 4'd0;
            end
          end else begin
            w_cand_nxt   = color;
            w_streak_nxt = 4'd1;
          end
        end
        S_LOCKED: begin
          if (w_hit) begin
            w_rel_nxt = 4'd0;
          end else begin
            w_rel_nxt = w_rel_inc[3:0];
            if (w_rel_inc == LP_RELEASE) w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake: an event transfers on any edge where evt_valid and evt_ready are
  // both high; evt_valid/evt_color hold until then, and evt_ready is don't-care
  // while evt_valid is low. A confirm coinciding with a transfer refills the slot.
  always_comb begin
    w_hs       = r_evt_valid & evt_ready;
    w_load_evt = w_confirm & (~r_evt_valid | w_hs);
    w_drop     = w_confirm & r_evt_valid & ~evt_ready;
    w_led_nxt  = 3'b000;
    case (r_cand)
      2'd1:    w_led_nxt = 3'b001;
      2'd2:    w_led_nxt = 3'b010;
      2'd3:    w_led_nxt = 3'b100;
      default: w_led_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_evt_valid <= 1'b0;
      r_evt_color <= 2'd0;
      r_evt_count <= 8'd0;
      r_overrun   <= 1'b0;
      r_timer     <= 32'd0;
      r_led       <= 3'b000;
    end else begin
      if (w_load_evt) begin
        r_evt_valid <= 1'b1;
        r_evt_color <= r_cand;
      end else if (w_hs) begin
        r_evt_valid <= 1'b0;
      end
      if (w_hs)   r_evt_count <= r_evt_count + 8'd1;
      if (w_drop) r_overrun   <= 1'b1;
      // Dropped confirms still refresh the indicator.
      if (w_confirm) begin
        r_timer <= LP_HOLD;
        r_led   <= w_led_nxt;
      end else if (r_timer != 32'd0) begin
        r_timer <= r_timer - 32'd1;
        if (r_timer == 32'd1) r_led <= 3'b000;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_color = r_evt_color;
  assign evt_count = r_evt_count;
  assign overrun   = r_overrun;
  assign led_r     = r_led[0];
  assign led_g     = r_led[1];
  assign led_b     = r_led[2];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_colour_event_filter.sv
// Directed bench for colour_event_filter (CONFIRM_N=3, RELEASE_N=2, HOLD_CYCLES=10).
// Inputs change and outputs are checked on falling edges.
module tb_colour_event_filter;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [1:0] color = 2'd0;
  logic       detected = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_color;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_count;
  logic       overrun;
  logic       led_r, led_g, led_b;
  logic [1:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  colour_event_filter #(.CONFIRM_N(3), .RELEASE_N(2), .HOLD_CYCLES(10)) dut (
    .clk_50(clk_50), .reset(reset), .sample_valid(sample_valid), .color(color),
    .detected(detected), .evt_valid(evt_valid), .evt_color(evt_color),
    .evt_ready(evt_ready), .evt_count(evt_count), .overrun(overrun),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .dbg_state(dbg_state)
  );

  always #5 clk_50 = ~clk_50;

  task automatic step(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic drive_sample(input logic [1:0] c, input logic d);
    sample_valid = 1'b1;
    color        = c;
    detected     = d;
    @(negedge clk_50);
    sample_valid = 1'b0;
    color        = 2'd0;
    detected     = 1'b0;
  endtask

  task automatic hit(input logic [1:0] c);
    drive_sample(c, 1'b1);
  endtask

  task automatic miss();
    drive_sample(2'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    evt_ready = 1'b1;
    hit(2'd1); hit(2'd1);
    do_reset();
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", evt_valid); n_fail++; end
    n_cmp++; if (evt_color !== 2'd0) begin $display("FAIL rst_color: got %0d want 0", evt_color); n_fail++; end
    n_cmp++; if (evt_count !== 8'd0) begin $display("FAIL rst_count: got %0d want 0", evt_count); n_fail++; end
    n_cmp++; if (overrun !== 1'b0) begin $display("FAIL rst_overrun: got %b want 0", overrun); n_fail++; end
    n_cmp++; if ({led_r, led_g, led_b} !== 3'b000) begin $display("FAIL rst_leds: got %b want 000", {led_r, led_g, led_b}); n_fail++; end
  endtask

  task automatic test_basic();
    do_reset();
    evt_ready = 1'b1;
    hit(2'd1); hit(2'd1);
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL basic_early: got %b want 0", evt_valid); n_fail++; end
    hit(2'd1);
    n_cmp++; if (evt_valid !== 1'b1) begin $display("FAIL basic_valid: got %b want 1", evt_valid); n_fail++; end
    n_cmp++; if (evt_color !== 2'd1) begin $display("FAIL basic_color: got %0d want 1", evt_color); n_fail++; end
    n_cmp++; if ({led_r, led_g, led_b} !== 3'b100) begin $display("FAIL basic_led_on: got rgb=%b want 100", {led_r, led_g, led_b}); n_fail++; end
    step(1);
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL basic_accepted: got %b want 0", evt_valid); n_fail++; end
    n_cmp++; if (evt_count !== 8'd1) begin $display("FAIL basic_count: got %0d want 1", evt_count); n_fail++; end
    step(8);
    n_cmp++; if (led_r !== 1'b1) begin $display("FAIL basic_led_last: got %b want 1", led_r); n_fail++; end
    step(1);
    n_cmp++; if (led_r !== 1'b0) begin $display("FAIL basic_led_off: got %b want 0", led_r); n_fail++; end
  endtask

  task automatic test_switch();
    do_reset();
    evt_ready = 1'b1;
    hit(2'd2); hit(2'd2); hit(2'd3); hit(2'd3);
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL switch_early: got %b want 0", evt_valid); n_fail++; end
    hit(2'd3);
    n_cmp++; if (evt_valid !== 1'b1) begin $display("FAIL switch_valid: got %b want 1", evt_valid); n_fail++; end
    n_cmp++; if (evt_color !== 2'd3) begin $display("FAIL switch_color: got %0d want 3", evt_color); n_fail++; end
    n_cmp++; if ({led_r, led_g, led_b} !== 3'b001) begin $display("FAIL switch_led: got rgb=%b want 001", {led_r, led_g, led_b}); n_fail++; end
    step(1);
    n_cmp++; if (evt_count !== 8'd1) begin $display("FAIL switch_count: got %0d want 1", evt_count); n_fail++; end
  endtask

  task automatic test_rearm();
    do_reset();
    evt_ready = 1'b1;
    hit(2'd3); hit(2'd3); hit(2'd3);
    hit(2'd3); hit(2'd3); miss();
    hit(2'd3); hit(2'd3); hit(2'd3);
    step(1);
    n_cmp++; if (evt_count !== 8'd1) begin $display("FAIL rearm_locked_count: got %0d want 1", evt_count); n_fail++; end
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL rearm_locked_valid: got %b want 0", evt_valid); n_fail++; end
    miss(); miss();
    hit(2'd3); hit(2'd3); hit(2'd3);
    n_cmp++; if (evt_valid !== 1'b1) begin $display("FAIL rearm_second_valid: got %b want 1", evt_valid); n_fail++; end
    step(1);
    n_cmp++; if (evt_count !== 8'd2) begin $display("FAIL rearm_second_count: got %0d want 2", evt_count); n_fail++; end
  endtask

  task automatic test_overrun();
    do_reset();
    evt_ready = 1'b0;
    hit(2'd3); hit(2'd3); hit(2'd3);
    miss(); miss();
    hit(2'd1); hit(2'd1);
    n_cmp++; if (overrun !== 1'b0) begin $display("FAIL ovr_before: got %b want 0", overrun); n_fail++; end
    hit(2'd1);
    n_cmp++; if (evt_valid !== 1'b1) begin $display("FAIL ovr_valid: got %b want 1", evt_valid); n_fail++; end
    n_cmp++; if (evt_color !== 2'd3) begin $display("FAIL ovr_color: got %0d want 3", evt_color); n_fail++; end
    n_cmp++; if (overrun !== 1'b1) begin $display("FAIL ovr_flag: got %b want 1", overrun); n_fail++; end
    n_cmp++; if ({led_r, led_g, led_b} !== 3'b100) begin $display("FAIL ovr_led: got rgb=%b want 100", {led_r, led_g, led_b}); n_fail++; end
    evt_ready = 1'b1;
    step(1);
    n_cmp++; if (evt_count !== 8'd1) begin $display("FAIL ovr_count: got %0d want 1", evt_count); n_fail++; end
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL ovr_drained: got %b want 0", evt_valid); n_fail++; end
    n_cmp++; if (overrun !== 1'b1) begin $display("FAIL ovr_sticky: got %b want 1", overrun); n_fail++; end
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready = 1'b0;
    hit(2'd3); hit(2'd3); hit(2'd3);
    miss(); miss();
    hit(2'd2); hit(2'd2);
    evt_ready = 1'b1;
    hit(2'd2);
    n_cmp++; if (evt_valid !== 1'b1) begin $display("FAIL b2b_valid: got %b want 1", evt_valid); n_fail++; end
    n_cmp++; if (evt_color !== 2'd2) begin $display("FAIL b2b_color: got %0d want 2", evt_color); n_fail++; end
    n_cmp++; if (overrun !== 1'b0) begin $display("FAIL b2b_overrun: got %b want 0", overrun); n_fail++; end
    n_cmp++; if (evt_count !== 8'd1) begin $display("FAIL b2b_count1: got %0d want 1", evt_count); n_fail++; end
    step(1);
    n_cmp++; if (evt_count !== 8'd2) begin $display("FAIL b2b_count2: got %0d want 2", evt_count); n_fail++; end
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL b2b_drained: got %b want 0", evt_valid); n_fail++; end
  endtask

  task automatic test_reset_mid();
    do_reset();
    evt_ready = 1'b1;
    hit(2'd2); hit(2'd2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_cmp++; if ({evt_valid, evt_count, overrun, led_r, led_g, led_b} !== 12'd0) begin $display("FAIL mid_rst_outputs: got %h want 000", {evt_valid, evt_count, overrun, led_r, led_g, led_b}); n_fail++; end
    hit(2'd2);
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL mid_rst_one_hit: got %b want 0", evt_valid); n_fail++; end
    hit(2'd2);
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL mid_rst_two_hits: got %b want 0", evt_valid); n_fail++; end
    hit(2'd2);
    n_cmp++; if (evt_valid !== 1'b1) begin $display("FAIL mid_rst_event: got %b want 1", evt_valid); n_fail++; end
    n_cmp++; if (led_g !== 1'b1) begin $display("FAIL mid_rst_led: got %b want 1", led_g); n_fail++; end
    // Reset coinciding with the confirming sample wins.
    do_reset();
    hit(2'd1); hit(2'd1);
    reset = 1'b1;
    hit(2'd1);
    reset = 1'b0;
    n_cmp++; if ({evt_valid, led_r} !== 2'b00) begin $display("FAIL prio_rst: got %b want 00", {evt_valid, led_r}); n_fail++; end
    hit(2'd1);
    n_cmp++; if (evt_valid !== 1'b0) begin $display("FAIL prio_rst_streak: got %b want 0", evt_valid); n_fail++; end
  endtask

  initial begin
    step(1);
    test_reset();
    test_basic();
    test_switch();
    test_rearm();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/colour_event_filter.md
COLOUR_EVENT_FILTER -- requirements
Module: colour_event_filter

Interface
REQ-001 Parameter CONFIRM_N, default 3, consecutive identical detections needed to confirm a colour; legal range 2..15.
REQ-002 Parameter RELEASE_N, default 2, consecutive no-detect samples needed to re-arm after a confirm; legal range 1..15.
REQ-003 Parameter HOLD_CYCLES, default 50000000, LED on-time in clk_50 cycles after a confirm; legal range 1..2^32-1.
REQ-004 clk_50  in  1  the single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_valid  in  1  one-cycle strobe; color/detected hold a new classification frame.
REQ-007 color  in  2  classifier output: 0 white, 1 red, 2 green, 3 blue.
REQ-008 detected  in  1  classifier detect flag.
REQ-009 evt_valid  out  1  confirmed-colour event pending.
REQ-010 evt_color  out  2  colour of the pending event.
REQ-011 evt_ready  in  1  consumer accepts the event.
REQ-012 evt_count  out  8  count of accepted events; wraps 255->0.
REQ-013 overrun  out  1  sticky: a confirmed event was dropped.
REQ-014 led_r, led_g, led_b  out  1 each  one-hot indicator of the last confirmed colour.

Function
REQ-015 Inputs are sampled only in cycles with sample_valid=1; otherwise FSM, streak and release counters hold.
REQ-016 A sample is a hit when detected=1 and color!=0; all other samples are misses.
REQ-017 FSM states: IDLE, CONFIRM, LOCKED; reset state is IDLE.
REQ-018 IDLE: hit -> CONFIRM, cand<=color, streak<=1; miss -> stay IDLE.
REQ-019 CONFIRM, hit with color==cand: streak<=streak+1; when streak+1==CONFIRM_N, issue a confirm and go to LOCKED with rel<=0.
REQ-020 CONFIRM, hit with color!=cand: cand<=color, streak<=1, stay in CONFIRM.
REQ-021 CONFIRM, miss: go to IDLE, streak<=0.
REQ-022 LOCKED, miss: rel<=rel+1; when rel+1==RELEASE_N, go to IDLE.
REQ-023 LOCKED, hit (any colour): rel<=0, stay LOCKED; no new event is issued.
REQ-024 A confirm raises evt_valid and loads evt_color<=cand on the next clk_50 edge, one cycle after the confirming sample_valid cycle.
REQ-025 evt_valid and evt_color hold until a cycle with evt_valid=1 and evt_ready=1; evt_valid deasserts on the following edge unless REQ-027 applies.
REQ-026 A confirm while evt_valid=1 and evt_ready=0 drops the new event, keeps the old one, and sets overrun=1.
REQ-027 A confirm in the same cycle as a handshake loads the new event, keeps evt_valid=1, and does not set overrun.
REQ-028 evt_count increments by 1 per handshake, modulo 256.
REQ-029 Every confirm, including a dropped one, loads the LED timer with HOLD_CYCLES and drives the LEDs one-hot for cand; others are 0.
REQ-030 LED timer decrements by 1 each cycle while nonzero; when it reaches 0, all LEDs are 0 on the same edge.
REQ-031 A confirm during a running hold restarts the timer and switches the LED to the new colour.
REQ-032 evt_ready is ignored while evt_valid=0.

Reset
REQ-033 reset=1 on a clock edge forces: FSM IDLE, streak=0, rel=0, cand=0, evt_valid=0, evt_color=0, evt_count=0, overrun=0, LED timer=0, led_r/g/b=0.
REQ-034 reset has priority over all other inputs, including a confirm or handshake in the same cycle.
REQ-035 Reset mid-confirm or mid-hold discards the pending event and streak; the first post-reset hit starts streak at 1.

Verification (CONFIRM_N=3, RELEASE_N=2, HOLD_CYCLES=10)
REQ-036 Three hit samples with color=1, evt_ready=1 -> evt_valid=1 with evt_color=1 one cycle after the third strobe; led_r=1 for 10 cycles; evt_count=1 after the handshake.
REQ-037 Hits with colours 2,2,3,3,3 -> exactly one event, with evt_color=3.
REQ-038 Hits 3,3,3, then 3,3, then one miss, then 3,3,3 -> one event only; then miss, miss, then 3,3,3 -> a second event.
REQ-039 evt_ready=0; confirm blue; re-arm; confirm red -> evt_color stays 3, overrun=1, led_r=1; evt_ready=1 -> evt_count=1.
REQ-040 Confirm in the same cycle as a handshake of the previous event -> evt_valid stays 1 with the new colour, overrun=0.
REQ-041 reset asserted after two matching hits -> all outputs 0; one further matching hit gives no event; three further matching hits give an event.
